// File: rtl/alu_wb_packer_pkg.sv
// Shared types for the ALU write-back packer: FSM states, SEW encodings and
// the lane-placement helpers used to build register-file write entries.
package alu_wb_packer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] SEW_8  = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;

  localparam int VL_W   = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Byte lanes touched by element idx within its destination word.
  function automatic logic [BE_W-1:0] lane_bwe(input logic [2:0] sew,
                                               input logic [1:0] idx_lo);
    if (sew == SEW_8)       return 4'b0001 << idx_lo;
    else if (sew == SEW_16) return 4'b0011 << {idx_lo[0], 1'b0};
    else                    return 4'b1111;
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [2:0]        sew,
                                                  input logic [DATA_W-1:0] result);
    if (sew == SEW_8)       return {4{result[7:0]}};
    else if (sew == SEW_16) return {2{result[15:0]}};
    else                    return result;
  endfunction

endpackage

// File: rtl/alu_wb_packer_wb_fifo.sv
// Write-back FIFO: power-of-two ring buffer with registered occupancy count.
// Head entry is presented combinationally; push on a full FIFO requires a pop.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: storage is deliberately not reset; only pointers/count are, and
  // consumers never look at the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_wb_packer.sv
// Collects ALU element results of one vector instruction, packs them into
// register-file word writes by SEW, and queues them through wb_fifo.
module alu_wb_packer
  import alu_wb_packer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [2:0]        sew_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              alu_vld_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              mask_i,
  output logic              alu_stall_o,
  output logic              vrf_wvld_o,
  output logic [ADDR_W-1:0] vrf_waddr_o,
  output logic [DATA_W-1:0] vrf_wdata_o,
  output logic [BE_W-1:0]   vrf_bwe_o,
  input  logic              vrf_wrdy_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  state_t              state, state_nxt;
  logic [VL_W-1:0]     idx, vl_q, elem_off;
  logic [2:0]          sew_q;
  logic [ADDR_W-1:0]   base_q, waddr, head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [BE_W-1:0]     head_bwe;
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic                accept, push, pop, last_elem, drained;

  assign pop       = ~fifo_empty & vrf_wrdy_i;
  assign alu_stall_o = fifo_full & ~pop;
  assign accept    = alu_vld_i & ~alu_stall_o & (state == RUN);
  assign push      = accept & mask_i;
  assign last_elem = (idx == vl_q - VL_W'(1));
  assign drained   = (fifo_count == '0);

  // Word offset of the current element within the destination group.
  always_comb begin
    if (sew_q == SEW_8)       elem_off = idx >> 2;
    else if (sew_q == SEW_16) elem_off = idx >> 1;
    else                      elem_off = idx;
    waddr = base_q + ADDR_W'(elem_off);
  end

  assign push_entry = {waddr, lane_data(sew_q, alu_result_i), lane_bwe(sew_q, idx[1:0])};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_addr, head_data, head_bwe} = head_entry;
  assign vrf_wvld_o  = ~fifo_empty;
  assign vrf_waddr_o = fifo_empty ? '0 : head_addr;
  assign vrf_wdata_o = fifo_empty ? '0 : head_data;
  assign vrf_bwe_o   = fifo_empty ? '0 : head_bwe;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && vl_i != '0) state_nxt = RUN;
      RUN:     if (accept && last_elem)   state_nxt = DRAIN;
      DRAIN:   if (drained)               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      vl_q   <= '0;
      sew_q  <= '0;
      base_q <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= ((state == IDLE) && start_i && (vl_i == '0)) ||
                ((state == DRAIN) && drained);
      if (state == IDLE && start_i) begin
        vl_q   <= vl_i;
        sew_q  <= sew_i;
        base_q <= base_addr_i;
        idx    <= '0;
      end else if (accept) begin
        idx <= idx + VL_W'(1);
      end
    end
  end

endmodule
